// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtract-based GCD controller.
package gcd_pkg;

  localparam int CNT_W_DEFAULT    = 5;
  localparam int MAX_ITER_DEFAULT = 16;

  localparam logic SEL_LOAD = 1'b0;
  localparam logic SEL_SUB  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } gcd_state_t;

endpackage

// File: rtl/gcd_iter_cnt.sv
// Subtraction counter: cleared on operand load, saturates at MAX_ITER.
module gcd_iter_cnt #(
  parameter int CNT_W    = 5,
  parameter int MAX_ITER = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  assign at_max = (count == CNT_W'(MAX_ITER));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gcd_ctrl.sv
// Sequencer for the 4-bit subtract-based GCD datapath: load, subtract until
// equal, write result, with an iteration guard for non-terminating operands.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int MAX_ITER = MAX_ITER_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             equal_val,
  input  logic             less_val,
  output logic             A_sel,
  output logic             B_sel,
  output logic             AL,
  output logic             BL,
  output logic             res_L,
  output logic             rst_dp,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt,
  output gcd_state_t       state
);

  gcd_state_t state_q, state_d;
  logic       cnt_clear, cnt_inc, at_max;

  assign state  = state_q;
  assign rst_dp = rst;

  gcd_iter_cnt #(
    .CNT_W    (CNT_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .count  (iter_cnt),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake: start is a level request accepted only in IDLE; while busy it
  // is ignored (not queued). Completion is the one-cycle done pulse, with err
  // alongside it when the iteration guard fired.
  always_comb begin
    state_d   = state_q;
    A_sel     = SEL_LOAD;
    B_sel     = SEL_LOAD;
    AL        = 1'b0;
    BL        = 1'b0;
    res_L     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        AL        = 1'b1;
        BL        = 1'b1;
        cnt_clear = 1'b1;
        state_d   = CALC;
      end
      CALC: begin
        // Equality wins over the guard so a run finishing on the last
        // permitted subtraction still reports a result.
        if (equal_val) begin
          state_d = WRITE;
        end else if (at_max) begin
          state_d = ERR;
        end else if (less_val) begin
          BL      = 1'b1;
          B_sel   = SEL_SUB;
          cnt_inc = 1'b1;
        end else begin
          AL      = 1'b1;
          A_sel   = SEL_SUB;
          cnt_inc = 1'b1;
        end
      end
      WRITE: begin
        res_L   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: a small datapath environment, a GCD reference model
// with a cycle schedule, a per-cycle compare process and directed runs.
module tb_gcd_ctrl;
  import gcd_pkg::*;

  localparam int CNT_W    = 5;
  localparam int MAX_ITER = 16;

  typedef struct {
    logic [3:0] res;
    int         k;
    bit         err;
  } run_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             equal_val, less_val;
  logic             A_sel, B_sel, AL, BL, res_L, rst_dp, busy, done, err;
  logic [CNT_W-1:0] iter_cnt;
  gcd_state_t       dbg_state;

  logic [3:0] op_a = 4'd0;
  logic [3:0] op_b = 4'd0;
  logic [3:0] reg_a, reg_b, reg_out;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  gcd_ctrl #(
    .CNT_W    (CNT_W),
    .MAX_ITER (MAX_ITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .equal_val (equal_val),
    .less_val  (less_val),
    .A_sel     (A_sel),
    .B_sel     (B_sel),
    .AL        (AL),
    .BL        (BL),
    .res_L     (res_L),
    .rst_dp    (rst_dp),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .iter_cnt  (iter_cnt),
    .state     (dbg_state)
  );

  // ---------------- datapath environment ----------------
  assign equal_val = (reg_a == reg_b);
  assign less_val  = (reg_a < reg_b);

  always @(posedge clk) begin
    if (rst_dp) begin
      reg_a   <= 4'd0;
      reg_b   <= 4'd0;
      reg_out <= 4'd0;
    end else begin
      if (AL)    reg_a   <= A_sel ? reg_a - reg_b : op_a;
      if (BL)    reg_b   <= B_sel ? reg_b - reg_a : op_b;
      if (res_L) reg_out <= reg_a;
    end
  end

  // ---------------- reference model ----------------
  function automatic run_t gcd_ref(input logic [3:0] a, input logic [3:0] b);
    run_t r;
    int   x, y;
    x = int'(a);
    y = int'(b);
    r.k   = 0;
    r.err = 1'b0;
    while (x != y) begin
      if (r.k == MAX_ITER) begin
        r.err = 1'b1;
        break;
      end
      if (x < y) y = y - x;
      else       x = x - y;
      r.k++;
    end
    r.res = x[3:0];
    return r;
  endfunction

  // Cycles from the IDLE cycle that accepts start to the done/err cycle.
  function automatic int run_latency(input run_t r);
    return r.err ? 3 + MAX_ITER : 4 + r.k;
  endfunction

  int         cyc        = 0;
  bit         m_busy     = 1'b0;
  int         m_start    = -10;
  int         m_done_at  = -10;
  int         m_iter     = 0;
  logic [3:0] m_last_res = 4'd0;
  run_t       m_run;
  logic [3:0] exp_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy     <= 1'b0;
      m_iter     <= 0;
      m_last_res <= 4'd0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (start) begin
        m_busy    <= 1'b1;
        m_start   <= cyc;
        m_run     <= gcd_ref(op_a, op_b);
        m_done_at <= cyc + run_latency(gcd_ref(op_a, op_b));
        if (!gcd_ref(op_a, op_b).err) exp_q.push_back(gcd_ref(op_a, op_b).res);
      end
    end else if (cyc == m_done_at) begin
      m_busy <= 1'b0;
      m_iter <= m_run.k;
      if (!m_run.err) m_last_res <= m_run.res;
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic e_done, e_load, e_write;
  assign e_done  = m_busy && (cyc == m_done_at);
  assign e_load  = m_busy && (cyc == m_start + 1);
  assign e_write = m_busy && !m_run.err && (cyc == m_done_at - 1);

  always @(negedge clk) begin
    if (check_en) begin
      check("busy",     32'(busy),   32'(m_busy));
      check("done",     32'(done),   32'(e_done));
      check("err",      32'(err),    32'(e_done && m_run.err));
      check("load_ab",  32'(AL && BL), 32'(e_load));
      check("res_L",    32'(res_L),  32'(e_write));
      check("rst_dp",   32'(rst_dp), 32'(rst));
      check("sel_gate", 32'((A_sel && !AL) || (B_sel && !BL)), 32'd0);
      if (!m_busy) begin
        check("idle_strobes", 32'({AL, BL, A_sel, B_sel, res_L}), 32'd0);
        check("iter_hold",    32'(iter_cnt), 32'(m_iter));
        check("res_hold",     32'(reg_out),  32'(m_last_res));
      end
      if (e_done) begin
        check("iter_done", 32'(iter_cnt), 32'(m_run.k));
        if (m_run.err) begin
          check("res_err_kept", 32'(reg_out), 32'(m_last_res));
        end else if (exp_q.size() == 0) begin
          check("res_queue_empty", 32'd0, 32'd1);
        end else begin
          check("res_done", 32'(reg_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_one(input logic [3:0] a, input logic [3:0] b,
                         input int exp_res, input int exp_k, input int exp_err,
                         input int exp_lat, input int repulse_at);
    int lat;
    bit seen;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    lat   = 0;
    seen  = 1'b0;
    while (lat < 40 && !seen) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (repulse_at != 0 && lat == repulse_at)     start = 1'b1;
      if (repulse_at != 0 && lat == repulse_at + 1) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        check("run_lat",  32'(lat),      32'(exp_lat));
        check("run_res",  32'(reg_out),  32'(exp_res));
        check("run_iter", 32'(iter_cnt), 32'(exp_k));
        check("run_err",  32'(err),      32'(exp_err));
      end
    end
    check("run_seen", 32'(seen), 32'd1);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    run_t r;
    int   n, last;

    r = gcd_ref(4'd12, 4'd8);
    check("ref_12_8_res", 32'(r.res), 32'd4);
    check("ref_12_8_k",   32'(r.k),   32'd2);
    r = gcd_ref(4'd15, 4'd1);
    check("ref_15_1_k",   32'(r.k),   32'd14);
    r = gcd_ref(4'd0, 4'd5);
    check("ref_0_5_err",  32'(r.err), 32'd1);
    check("ref_lat_9_6",  32'(run_latency(gcd_ref(4'd9, 4'd6))), 32'd6);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
    check("reset_busy", 32'(busy),     32'd0);
    check("reset_iter", 32'(iter_cnt), 32'd0);
    check("reset_done", 32'({done, err}), 32'd0);

    run_one(4'd12, 4'd8, 4,  2, 0, 6,  0);
    run_one(4'd7,  4'd7, 7,  0, 0, 4,  0);
    run_one(4'd15, 4'd1, 1, 14, 0, 18, 0);
    run_one(4'd0,  4'd5, 1, 16, 1, 19, 0);
    run_one(4'd12, 4'd8, 4,  2, 0, 6,  3);

    // Reset during CALC of a fresh run: cycle T3 carries rst.
    @(negedge clk);
    op_a  = 4'd12;
    op_b  = 4'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_rst_dp", 32'(rst_dp), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", 32'({busy, done, err}), 32'd0);
    check("midrst_iter", 32'(iter_cnt), 32'd0);
    repeat (2) @(negedge clk);
    run_one(4'd12, 4'd8, 4, 2, 0, 6, 0);

    // Start held high: each k=2 run is 7 cycles IDLE..DONE, then restarts.
    @(negedge clk);
    op_a  = 4'd9;
    op_b  = 4'd6;
    start = 1'b1;
    n     = 0;
    last  = -1;
    for (int c = 1; c <= 40 && n < 3; c++) begin
      @(negedge clk);
      if (done) begin
        check("hold_res", 32'(reg_out), 32'd3);
        if (last >= 0) check("hold_gap", 32'(c - last), 32'd7);
        last = c;
        n++;
      end
    end
    start = 1'b0;
    check("hold_runs", 32'(n), 32'd3);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
